// File: rtl/gate_truth_table_checker.sv
// On-chip self-test for a two-input gate block: walks {A,B} through 00..11,
// waits a settle time per vector and checks Y/Z against truth tables.
module gate_truth_table_checker #(
  parameter int          SETTLE_CYCLES = 2,
  parameter int          REPEAT        = 1,
  parameter logic [3:0]  Y_TRUTH       = 4'b0111,
  parameter logic [3:0]  Z_TRUTH       = 4'b1000,
  parameter int          CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             y_in,
  input  logic             z_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic [1:0]       fail_yz
);

  // state  | meaning
  // IDLE   | waiting for start
  // SETTLE | vector applied, settle timer counting down
  // SAMPLE | one-cycle compare of y_in/z_in against the truth tables
  // DONE   | run complete, results held until next start
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SWEEP_LAST  = SW'(REPEAT - 1);

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [1:0]      vec;
  logic [SW-1:0]   sweep;
  logic            start_run;
  logic            last_vec;
  logic            mismatch;
  logic            in_busy;

  assign in_busy   = (state == SETTLE) || (state == SAMPLE);
  assign start_run = ((state == IDLE) || (state == DONE)) && start && !abort;
  assign last_vec  = (vec == 2'd3) && (sweep == SWEEP_LAST);
  assign mismatch  = (y_in != Y_TRUTH[vec]) || (z_in != Z_TRUTH[vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_run) state_nxt = SETTLE;
      SETTLE:  if (abort) state_nxt = IDLE;
               else if (timer == '0) state_nxt = SAMPLE;
      SAMPLE:  if (abort) state_nxt = IDLE;
               else if (last_vec) state_nxt = DONE;
               else state_nxt = SETTLE;
      DONE:    if (start_run) state_nxt = SETTLE;
               else if (start && abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = in_busy;
    done = (state == DONE);
    pass = (state == DONE) && (err_count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      vec        <= '0;
      sweep      <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_yz    <= '0;
    end else if (start_run) begin
      timer      <= SETTLE_LOAD;
      vec        <= '0;
      sweep      <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_yz    <= '0;
    end else if (state == SETTLE) begin
      if (timer != '0) timer <= timer - 1'b1;
      if (abort) begin
        a_out <= 1'b0;
        b_out <= 1'b0;
      end
    end else if (state == SAMPLE) begin
      // The compare is recorded even when abort lands in this cycle.
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= vec;
          fail_yz    <= {y_in, z_in};
        end
      end
      if (abort || last_vec) begin
        a_out <= 1'b0;
        b_out <= 1'b0;
      end else begin
        vec   <= vec + 2'd1;
        a_out <= (vec + 2'd1) >> 1 != 2'd0;
        b_out <= !vec[0];
        timer <= SETTLE_LOAD;
        if (vec == 2'd3) sweep <= sweep + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: good gate, stuck-at faults,
// repeat sweeps, saturation, abort and mid-run reset.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start12 = 1'b0, abort = 1'b0;
  logic y0_stuck0 = 1'b0;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  logic a0, b0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [1:0] fvec0, fyz0;
  logic y0, z0;
  assign y0 = y0_stuck0 ? 1'b0 : ~(a0 & b0);
  assign z0 = a0 & b0;

  gate_truth_table_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .y_in(y0), .z_in(z0), .a_out(a0), .b_out(b0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fv0),
    .fail_vec(fvec0), .fail_yz(fyz0));

  logic a1, b1, busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [1:0] fvec1, fyz1;
  logic y1, z1;
  assign y1 = ~(a1 & b1);
  assign z1 = 1'b1;

  gate_truth_table_checker #(.REPEAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start12), .abort(abort),
    .y_in(y1), .z_in(z1), .a_out(a1), .b_out(b1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1),
    .fail_vec(fvec1), .fail_yz(fyz1));

  logic a2, b2, busy2, done2, pass2, fv2;
  logic [1:0] err2;
  logic [1:0] fvec2, fyz2;
  logic y2, z2;
  assign y2 = 1'b0;
  assign z2 = a2 & b2;

  gate_truth_table_checker #(.REPEAT(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start12), .abort(abort),
    .y_in(y2), .z_in(z2), .a_out(a2), .b_out(b2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err2), .fail_valid(fv2),
    .fail_vec(fvec2), .fail_yz(fyz2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic go_to(input int k);
    while (cyc < k) tick();
  endtask

  // Pulse start0 in the current cycle, which becomes cycle 0.
  task automatic start_dut0();
    cyc = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_done", {7'd0, done0}, 8'd0);
    chk("reset_all", {a0, b0, busy0, pass0, fv0, err0[2:0]}, 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Test 1: good gate
    start_dut0();
    chk("t1_busy_c1", {7'd0, busy0}, 8'd1);
    chk("t1_ab_v0", {6'd0, a0, b0}, 8'd0);
    go_to(4);  chk("t1_ab_v1", {6'd0, a0, b0}, 8'd1);
    go_to(6);  chk("t1_ab_v1_hold", {6'd0, a0, b0}, 8'd1);
    go_to(7);  chk("t1_ab_v2", {6'd0, a0, b0}, 8'd2);
    go_to(10); chk("t1_ab_v3", {6'd0, a0, b0}, 8'd3);
    go_to(12); chk("t1_done_c12", {6'd0, done0, busy0}, 8'd1);
    go_to(13);
    chk("t1_done_c13", {6'd0, done0, busy0}, 8'd2);
    chk("t1_pass", {7'd0, pass0}, 8'd1);
    chk("t1_err", {4'd0, err0}, 8'd0);
    chk("t1_fv", {7'd0, fv0}, 8'd0);
    chk("t1_ab_done", {6'd0, a0, b0}, 8'd0);
    go_to(16); chk("t1_done_held", {7'd0, done0}, 8'd1);

    // Test 2: Y stuck at 0
    y0_stuck0 = 1'b1;
    start_dut0();
    chk("t2_done_cleared", {7'd0, done0}, 8'd0);
    go_to(13);
    chk("t2_done", {7'd0, done0}, 8'd1);
    chk("t2_err", {4'd0, err0}, 8'd3);
    chk("t2_fv", {7'd0, fv0}, 8'd1);
    chk("t2_fvec", {6'd0, fvec0}, 8'd0);
    chk("t2_fyz", {6'd0, fyz0}, 8'd0);
    chk("t2_pass", {7'd0, pass0}, 8'd0);
    y0_stuck0 = 1'b0;

    // Tests 3 and 4: REPEAT=2 with Z stuck at 1, and CNT_W=2 saturation
    cyc = 0;
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    go_to(13); chk("t3_ab_sweep2", {6'd0, a1, b1}, 8'd0);
    chk("t3_busy_sweep2", {7'd0, busy1}, 8'd1);
    go_to(24); chk("t3_done_c24", {7'd0, done1}, 8'd0);
    go_to(25);
    chk("t3_done_c25", {7'd0, done1}, 8'd1);
    chk("t3_err", {4'd0, err1}, 8'd6);
    chk("t3_fvec", {6'd0, fvec1}, 8'd0);
    chk("t3_fyz", {6'd0, fyz1}, 8'd3);
    chk("t3_pass", {7'd0, pass1}, 8'd0);
    chk("t4_done", {7'd0, done2}, 8'd1);
    chk("t4_err_sat", {6'd0, err2}, 8'd3);
    chk("t4_pass", {7'd0, pass2}, 8'd0);

    // Test 5: start while busy is ignored, abort returns to IDLE
    start_dut0();
    go_to(3);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("t5_ab_after_busy_start", {6'd0, a0, b0}, 8'd1);
    go_to(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_idle_busy", {7'd0, busy0}, 8'd0);
    chk("t5_idle_ab", {6'd0, a0, b0}, 8'd0);
    chk("t5_err_partial", {4'd0, err0}, 8'd0);
    go_to(12); chk("t5_no_done", {6'd0, done0, busy0}, 8'd0);
    start0 = 1'b1;
    abort  = 1'b1;
    tick();
    start0 = 1'b0;
    abort  = 1'b0;
    chk("t5_start_abort_idle", {6'd0, done0, busy0}, 8'd0);
    start_dut0();
    go_to(12); chk("t5_rerun_c12", {7'd0, done0}, 8'd0);
    go_to(13); chk("t5_rerun_done", {6'd0, done0, pass0}, 8'd3);

    // Test 6: asynchronous reset mid-run
    y0_stuck0 = 1'b1;
    start_dut0();
    go_to(6); chk("t6_err_before", {4'd0, err0}, 8'd1);
    go_to(7);
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", {a0, b0, busy0, done0, pass0, fv0, 2'd0}, 8'd0);
    chk("t6_reset_err", {4'd0, err0}, 8'd0);
    tick();
    chk("t6_still_idle", {7'd0, busy0}, 8'd0);
    rst_n = 1'b1;
    y0_stuck0 = 1'b0;
    tick();
    start_dut0();
    go_to(13);
    chk("t6_rerun_done", {6'd0, done0, pass0}, 8'd3);
    chk("t6_rerun_clear", {3'd0, fv0, err0}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
